seg_scan_sched: RTL and testbench

Time-multiplexed scan scheduler for the board's 8-digit, common-anode 7-segment display.
- Holds a double-buffered 8-entry digit register file, loaded through a valid/ready write port.
- Commits new contents only at frame boundaries, so a multi-digit update never appears half-applied on the display.
- Sequences the AN/A2G pins, applies per-digit blanking and a 16-level brightness duty cycle.
- Sits between board-level logic (switch/LED glue, future counters) and the display pins.

---
 rtl/seg_scan_sched.sv | 121 ++++++++++++
 tb/tb_seg_scan_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_sched.sv
// 8-digit 7-segment scan scheduler: double-buffered digit file, commits at frame boundaries.
// Outputs registered (1 cycle after slot/dwell); write port stalls (wr_ready=0) while a commit is pending.
module seg_scan_sched #(
    parameter int DWELL_W = 17
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_idx,
    input  logic [4:0] wr_data,
    input  logic       wr_last,
    input  logic [3:0] bright,
    output logic       frame_done,
    output logic [7:0] AN,
    output logic [6:0] A2G
);

    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [2:0]         slot_q, slot_d;
    logic [4:0]         shadow_q [8];
    logic [4:0]         shadow_d [8];
    logic [4:0]         active_q [8];
    logic [4:0]         active_d [8];
    logic               pending_q, pending_d;
    logic               frame_done_q, frame_done_d;
    logic [7:0]         an_q, an_d;
    logic [6:0]         a2g_q, a2g_d;

    logic               slot_end;
    logic               boundary;
    logic               xfer;
    logic [4:0]         cur;
    logic [3:0]         phase;
    logic               lit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        slot_end = &dwell_q;
        boundary = slot_end && (slot_q == 3'd7);
        xfer     = wr_valid && !pending_q;

        dwell_d  = dwell_q + 1'b1;
        slot_d   = slot_end ? slot_q + 3'd1 : slot_q;

        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (xfer)
            shadow_d[wr_idx] = wr_data;
        // A commit only happens with pending set, and then no transfer can occur.
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (xfer && wr_last)
            pending_d = 1'b1;

        frame_done_d = boundary;

        cur   = active_q[slot_q];
        phase = dwell_q[DWELL_W-1 -: 4];
        lit   = (phase < bright) && !cur[4];
        an_d  = 8'hFF;
        a2g_d = 7'h7F;
        if (lit) begin
            an_d  = ~(8'b1 << slot_q);
            a2g_d = hex7(cur[3:0]);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            dwell_q      <= '0;
            slot_q       <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= 8'hFF;
            a2g_q        <= 7'h7F;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 5'h10;
                active_q[i] <= 5'h10;
            end
        end else begin
            dwell_q      <= dwell_d;
            slot_q       <= slot_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            a2g_q        <= a2g_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    assign wr_ready   = ~pending_q;
    assign frame_done = frame_done_q;
    assign AN         = an_q;
    assign A2G        = a2g_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Bench for seg_scan_sched with DWELL_W=4 (16 cycles/slot, 128 cycles/frame).
module tb_seg_scan_sched;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_idx;
    logic [4:0] wr_data;
    logic       wr_last;
    logic [3:0] bright;
    logic       frame_done;
    logic [7:0] AN;
    logic [6:0] A2G;

    seg_scan_sched #(.DWELL_W(4)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .bright    (bright),
        .frame_done(frame_done),
        .AN        (AN),
        .A2G       (A2G)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [3:0] val;
        logic [6:0] exp_a2g;
    } hex_vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: time since reset plus the two digit buffers.
    int         t;
    logic [4:0] m_sh  [8];
    logic [4:0] m_act [8];
    logic       m_pend;
    int         fd_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        t      = 0;
        m_pend = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_sh[i]  = 5'h10;
            m_act[i] = 5'h10;
        end
    endtask

    // One clock: predict from the model, advance, compare at the falling edge.
    task automatic step();
        int         sl;
        int         ph;
        logic       lit;
        logic       xfer;
        logic [7:0] e_an;
        logic [6:0] e_a2g;
        logic       e_fd;
        sl    = (t / 16) % 8;
        ph    = t % 16;
        lit   = (ph < int'(bright)) && !m_act[sl][4];
        e_an  = lit ? ~(8'h01 << sl) : 8'hFF;
        e_a2g = lit ? HEX[m_act[sl][3:0]] : 7'h7F;
        e_fd  = (t % 128) == 127;
        xfer  = wr_valid && !m_pend;
        if (e_fd && m_pend) begin
            for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
            m_pend = 1'b0;
        end
        if (xfer) begin
            m_sh[wr_idx] = wr_data;
            if (wr_last) m_pend = 1'b1;
        end
        @(posedge clk);
        t++;
        @(negedge clk);
        chk("AN", AN, e_an);
        chk("A2G", A2G, e_a2g);
        chk("frame_done", frame_done, e_fd);
        chk("wr_ready", wr_ready, !m_pend);
        if (frame_done) fd_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int m);
        for (int i = 0; i < 128 && (t % 128) != m; i++) step();
    endtask

    task automatic write1(input logic [2:0] idx, input logic [4:0] dat, input logic last);
        wr_valid = 1'b1;
        wr_idx   = idx;
        wr_data  = dat;
        wr_last  = last;
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    hex_vec_t hv [16];
    int       cnt, cnt2;

    initial begin
        for (int i = 0; i < 16; i++) begin
            hv[i].val     = 4'(i);
            hv[i].exp_a2g = 7'h7F;
        end
        hv[0].exp_a2g  = 7'h40; hv[1].exp_a2g  = 7'h79; hv[2].exp_a2g  = 7'h24; hv[3].exp_a2g  = 7'h30;
        hv[4].exp_a2g  = 7'h19; hv[5].exp_a2g  = 7'h12; hv[6].exp_a2g  = 7'h02; hv[7].exp_a2g  = 7'h78;
        hv[8].exp_a2g  = 7'h00; hv[9].exp_a2g  = 7'h10; hv[10].exp_a2g = 7'h08; hv[11].exp_a2g = 7'h03;
        hv[12].exp_a2g = 7'h46; hv[13].exp_a2g = 7'h21; hv[14].exp_a2g = 7'h06; hv[15].exp_a2g = 7'h0E;

        rst_n = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_data = '0; wr_last = 1'b0; bright = 4'd15;
        fd_cnt = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_AN", AN, 8'hFF);
        chk("rst_A2G", A2G, 7'h7F);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;

        // Idle frames: dark display, one frame_done per 128 cycles.
        run(384);
        chk("idle_fd_count", fd_cnt, 3);

        // Single digit write to idx 3.
        run_to(20);
        write1(3'd3, 5'h01, 1'b1);
        chk("single_wr_ready_low", wr_ready, 1'b0);
        run_to(0);
        chk("single_wr_ready_back", wr_ready, 1'b1);
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            if (AN == 8'hF7 && A2G == 7'h79) cnt++;
            else if (AN != 8'hFF) cnt2++;
        end
        chk("single_lit_cycles", cnt, 15);
        chk("single_other_lit", cnt2, 0);

        // Batch of 8 writes spread mid-frame, commit at the boundary.
        run_to(2);
        for (int i = 0; i < 8; i++) begin
            write1(3'(i), 5'(i), i == 7);
            run(5);
        end
        run_to(0);
        cnt = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            if (AN == 8'h7F && A2G == 7'h78) cnt++;
        end
        chk("batch_slot7_cycles", cnt, 15);

        // Brightness: 0, 8, and a mid-slot change 4 -> 14.
        bright = 4'd0;
        cnt = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            if (AN != 8'hFF) cnt++;
        end
        chk("bright0_lit", cnt, 0);
        bright = 4'd8;
        run_to(16);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (AN != 8'hFF) cnt++;
        end
        chk("bright8_lit", cnt, 8);
        bright = 4'd4;
        run_to(32);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) bright = 4'd14;
            step();
            if (AN != 8'hFF) cnt++;
        end
        chk("bright_change_lit", cnt, 10);
        bright = 4'd15;

        // Hex decode table, one digit at a time on slot 0.
        for (int k = 0; k < 16; k++) begin
            run_to(40);
            write1(3'd0, {1'b0, hv[k].val}, 1'b1);
            run_to(0);
            step();
            step();
            chk("hex_AN", AN, 8'hFE);
            chk("hex_A2G", A2G, hv[k].exp_a2g);
        end

        // wr_last landing exactly in the boundary cycle: commit one frame later.
        run_to(127);
        write1(3'd5, 5'h0A, 1'b1);
        chk("bnd_wr_ready_low", wr_ready, 1'b0);
        run_to(126);
        chk("bnd_still_pending", wr_ready, 1'b0);
        run(2);
        chk("bnd_committed", wr_ready, 1'b1);
        run(128);

        // Asynchronous reset mid-frame with a commit pending.
        run_to(50);
        write1(3'd1, 5'h07, 1'b1);
        run_to(16 + 3);
        step();
        chk("prereset_lit", AN, 8'hFD);
        #1 rst_n = 1'b0;
        #1;
        chk("async_AN", AN, 8'hFF);
        chk("async_A2G", A2G, 7'h7F);
        chk("async_wr_ready", wr_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(300);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_idx   = 3'($urandom);
            wr_data  = 5'($urandom);
            wr_last  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) bright = 4'($urandom);
            step();
        end
        wr_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
